// File: rtl/shor_claim_verifier.sv
`default_nettype none
// ============================================================================
// Module   : shor_claim_verifier
// Purpose  : Independently checks a claimed Shor certificate (N, a, r, p, q):
//            p*q == N, a^r == 1 (mod N), minimality of r (optional) and
//            whether gcd(a^(r/2)-1, N) reproduces p or q. Charges mu-cost for
//            every unit of verification work; any bad claim is rejected.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready      : claim handshake (ready only in IDLE)
//            N, a, r, p, q          : claimed certificate, WIDTH bits each
//            out_valid/out_ready    : verdict handshake, verdict held until taken
//            accept                 : overall verdict
//            status[4:0]            : {input_error, derived_ok, minimal_ok,
//                                      period_ok, product_ok}
//            mu_cost                : saturating mu-bits charged for the claim
//            busy                   : high from capture until out_valid
// Options  : SHOR_MINIMALITY_CHECK_EN enables the minimality scan of r.
// Revision : 1.0 - initial release
// ============================================================================
module shor_claim_verifier #(
    parameter int WIDTH      = 32,
    parameter int MAX_PERIOD = 256,
    parameter int MU_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    N,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    r,
    input  logic [WIDTH-1:0]    p,
    input  logic [WIDTH-1:0]    q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                accept,
    output logic [4:0]          status,
    output logic [MU_WIDTH-1:0] mu_cost,
    output logic                busy
);

`ifdef SHOR_MINIMALITY_CHECK_EN
    localparam logic c_MIN_SCAN_EN = 1'b1;
`else
    localparam logic c_MIN_SCAN_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_TWO  = WIDTH'(2);
    localparam logic [WIDTH-1:0] c_MAXP = WIDTH'(MAX_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRECHECK = 3'd1,
        S_POW_R    = 3'd2,
        S_POW_HALF = 3'd3,
        S_GCD      = 3'd4,
        S_MIN_SCAN = 3'd5,
        S_RESULT   = 3'd6,
        S_HOLD     = 3'd7
    } state_t;

    // (x*y) mod m over the full double-width product.
    function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [WIDTH-1:0] m);
        logic [2*WIDTH-1:0] prod;
        prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        if (m == c_ZERO)
            return c_ZERO;
        return WIDTH'(prod % {{WIDTH{1'b0}}, m});
    endfunction

    // Saturating mu-cost accumulation: the counter pins at all-ones.
    function automatic logic [MU_WIDTH-1:0] mu_add(input logic [MU_WIDTH-1:0] m,
                                                   input logic [2:0]          inc);
        logic [MU_WIDTH:0] sum;
        sum = {1'b0, m} + {{(MU_WIDTH-2){1'b0}}, inc};
        return sum[MU_WIDTH] ? {MU_WIDTH{1'b1}} : sum[MU_WIDTH-1:0];
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_n, r_a_r, r_r, r_p, r_q;
    logic [WIDTH-1:0]      r_acc, r_base, r_e;
    logic [WIDTH-1:0]      r_x, r_y;
    logic [WIDTH-1:0]      r_res, r_k;
    logic [4:0]            r_status;
    logic                  r_accept;
    logic [MU_WIDTH-1:0]   r_mu;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [WIDTH-1:0]      w_acc_step, w_base_sq, w_e_shr, w_res_mul, w_y_rem;
    logic [WIDTH-1:0]      w_cap_a_r, w_h_dec;
    logic                  w_pow_done, w_in_err, w_prod_ok, w_skip_scan;
    logic                  w_scan_hit, w_scan_last;

    // Shared datapath: one modular-exponentiation step, one Euclid step and
    // one minimality-scan step, each selected by the current state.
    always_comb begin
        w_acc_step  = r_e[0] ? mulmod(r_acc, r_base, r_n) : r_acc;
        w_base_sq   = mulmod(r_base, r_base, r_n);
        w_e_shr     = r_e >> 1;
        w_pow_done  = (w_e_shr == c_ZERO);
        w_res_mul   = mulmod(r_res, r_a_r, r_n);
        w_y_rem     = (r_y == c_ZERO) ? c_ZERO : (r_x % r_y);
        w_cap_a_r   = (N == c_ZERO) ? c_ZERO : (a % N);
        // gcd argument a^(r/2)-1 taken modulo N, so h==0 wraps to N-1.
        w_h_dec     = (w_acc_step == c_ZERO) ? (r_n - c_ONE) : (w_acc_step - c_ONE);
        w_in_err    = (r_n < c_TWO) | (r_r == c_ZERO) | (r_r > c_MAXP);
        w_prod_ok   = (r_p > c_ONE) & (r_q > c_ONE) &
                      (({{WIDTH{1'b0}}, r_p} * {{WIDTH{1'b0}}, r_q}) == {{WIDTH{1'b0}}, r_n});
        // r==1 has no k in 1..r-1 to test, so the scan is skipped as trivially minimal.
        w_skip_scan = !c_MIN_SCAN_EN | (r_r == c_ONE);
        w_scan_hit  = (w_res_mul == c_ONE);
        w_scan_last = (r_k == (r_r - c_ONE));
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_state_nxt = S_PRECHECK;
            end
            S_PRECHECK: w_state_nxt = w_in_err ? S_RESULT : S_POW_R;
            S_POW_R: begin
                if (w_pow_done) begin
                    if (!r_r[0])
                        w_state_nxt = S_POW_HALF;
                    else
                        w_state_nxt = w_skip_scan ? S_RESULT : S_MIN_SCAN;
                end
            end
            S_POW_HALF: begin
                if (w_pow_done)
                    w_state_nxt = S_GCD;
            end
            S_GCD: begin
                if (r_y == c_ZERO)
                    w_state_nxt = w_skip_scan ? S_RESULT : S_MIN_SCAN;
            end
            S_MIN_SCAN: begin
                if (w_scan_hit | w_scan_last)
                    w_state_nxt = S_RESULT;
            end
            S_RESULT:   w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (out_ready)
                    w_state_nxt = S_IDLE;
            end
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n         <= '0;
            r_a_r       <= '0;
            r_r         <= '0;
            r_p         <= '0;
            r_q         <= '0;
            r_acc       <= '0;
            r_base      <= '0;
            r_e         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_status    <= '0;
            r_accept    <= 1'b0;
            r_mu        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_n      <= N;
                        r_a_r    <= w_cap_a_r;
                        r_r      <= r;
                        r_p      <= p;
                        r_q      <= q;
                        r_mu     <= '0;
                        r_status <= '0;
                        r_accept <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_PRECHECK: begin
                    r_mu <= mu_add(r_mu, 3'd4);
                    if (w_in_err) begin
                        r_status[4] <= 1'b1;
                    end else begin
                        r_status[0] <= w_prod_ok;
                        r_acc       <= c_ONE;
                        r_base      <= r_a_r;
                        r_e         <= r_r;
                    end
                end
                S_POW_R: begin
                    r_acc  <= w_acc_step;
                    r_base <= w_base_sq;
                    r_e    <= w_e_shr;
                    r_mu   <= mu_add(r_mu, 3'd2);
                    if (w_pow_done) begin
                        r_status[1] <= (w_acc_step == c_ONE);
                        if (!r_r[0]) begin
                            r_acc  <= c_ONE;
                            r_base <= r_a_r;
                            r_e    <= r_r >> 1;
                        end else begin
                            r_res       <= c_ONE;
                            r_k         <= c_ONE;
                            r_status[2] <= c_MIN_SCAN_EN & (r_r == c_ONE);
                        end
                    end
                end
                S_POW_HALF: begin
                    r_acc  <= w_acc_step;
                    r_base <= w_base_sq;
                    r_e    <= w_e_shr;
                    r_mu   <= mu_add(r_mu, 3'd2);
                    if (w_pow_done) begin
                        r_x <= w_h_dec;
                        r_y <= r_n;
                    end
                end
                S_GCD: begin
                    if (r_y != c_ZERO) begin
                        r_x  <= r_y;
                        r_y  <= w_y_rem;
                        r_mu <= mu_add(r_mu, 3'd1);
                    end else begin
                        r_status[3] <= (r_x == r_p) | (r_x == r_q);
                        r_res       <= c_ONE;
                        r_k         <= c_ONE;
                        r_status[2] <= 1'b0;
                    end
                end
                S_MIN_SCAN: begin
                    r_res <= w_res_mul;
                    r_k   <= r_k + c_ONE;
                    r_mu  <= mu_add(r_mu, 3'd1);
                    if (w_scan_hit)
                        r_status[2] <= 1'b0;
                    else if (w_scan_last)
                        r_status[2] <= 1'b1;
                end
                S_RESULT: begin
                    // derived_ok (status[3]) is informational and not part of the verdict.
                    r_accept    <= r_status[0] & r_status[1] &
                                   (r_status[2] | !c_MIN_SCAN_EN) & !r_status[4];
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                end
                S_HOLD: begin
                    if (out_ready)
                        r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign accept    = r_accept;
    assign status    = r_status;
    assign mu_cost   = r_mu;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shor_claim_verifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shor_claim_verifier
// Purpose  : Self-checking bench for shor_claim_verifier. A value-level model
//            (plain modular arithmetic, Euclid, linear order search) predicts
//            verdict, status, mu-cost and latency for every claim; a monitor
//            compares DUT outputs against it on every cycle.
// Options  : honours SHOR_MINIMALITY_CHECK_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shor_claim_verifier;

    localparam int WIDTH      = 32;
    localparam int MAX_PERIOD = 256;
    localparam int MU_WIDTH   = 16;

`ifdef SHOR_MINIMALITY_CHECK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic                clk       = 1'b0;
    logic                rst_n     = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic [WIDTH-1:0]    N = '0, a = '0, r = '0, p = '0, q = '0;
    logic                in_ready, out_valid, accept, busy;
    logic [4:0]          status;
    logic [MU_WIDTH-1:0] mu_cost;

    int   checks   = 0;
    int   failures = 0;
    bit   in_flight = 1'b0;
    bit   exp_accept = 1'b0;
    logic [4:0] exp_status = '0;
    int   exp_mu  = 0;
    int   exp_lat = 0;

    shor_claim_verifier #(
        .WIDTH      (WIDTH),
        .MAX_PERIOD (MAX_PERIOD),
        .MU_WIDTH   (MU_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .a         (a),
        .r         (r),
        .p         (p),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .accept    (accept),
        .status    (status),
        .mu_cost   (mu_cost),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int bitlen(input longint unsigned v);
        int b = 0;
        while (v != 0) begin
            b++;
            v = v >> 1;
        end
        return b;
    endfunction

    // Smallest k in 1..256 with ar^k == 1 mod n, else 0.
    function automatic int order_of(input longint unsigned ar, input longint unsigned n);
        longint unsigned res = 1;
        for (int k = 1; k <= 256; k++) begin
            res = (res * ar) % n;
            if (res == 1) return k;
        end
        return 0;
    endfunction

    // Reference model; latency counts clock edges from capture to out_valid.
    task automatic model(input longint unsigned n, input longint unsigned av,
                         input longint unsigned rv, input longint unsigned pv,
                         input longint unsigned qv,
                         output bit m_acc, output logic [4:0] m_st,
                         output int m_mu, output int m_lat);
        longint unsigned ar, pw, h, x, y, t, res;
        int gsteps;
        bit pok, perok, minok, dok;
        m_mu  = 4;
        m_lat = 2;
        m_acc = 1'b0;
        m_st  = 5'b10000;
        if (n < 2 || rv == 0 || rv > MAX_PERIOD) return;
        ar  = av % n;
        pok = (pv > 1) && (qv > 1) && (pv * qv == n);
        pw = 1;
        for (longint unsigned k = 0; k < rv; k++) pw = (pw * ar) % n;
        perok = (pw == 1);
        m_mu  += 2 * bitlen(rv);
        m_lat += bitlen(rv);
        dok = 1'b0;
        if (rv % 2 == 0) begin
            h = 1;
            for (longint unsigned k = 0; k < rv / 2; k++) h = (h * ar) % n;
            m_mu  += 2 * bitlen(rv / 2);
            m_lat += bitlen(rv / 2);
            x = (h == 0) ? n - 1 : h - 1;
            y = n;
            gsteps = 0;
            while (y != 0) begin
                t = x % y;
                x = y;
                y = t;
                gsteps++;
            end
            m_mu  += gsteps;
            m_lat += gsteps + 1;
            dok = (x == pv) || (x == qv);
        end
        minok = 1'b0;
        if (EN) begin
            minok = 1'b1;
            res = 1;
            for (longint unsigned k = 1; k < rv; k++) begin
                res = (res * ar) % n;
                m_mu++;
                m_lat++;
                if (res == 1) begin
                    minok = 1'b0;
                    break;
                end
            end
        end
        m_acc = pok && perok && (minok || !EN);
        m_st  = {1'b0, dok, minok, perok, pok};
        if (m_mu > 65535) m_mu = 65535;
    endtask

    // Per-cycle comparison of DUT outputs against the model's prediction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                check("ov_unexpected", in_flight, 1);
                check("accept", accept, exp_accept);
                check("status", status, exp_status);
                check("mu_cost", mu_cost, exp_mu);
                check("busy_at_ov", busy, 0);
                check("in_ready_at_ov", in_ready, 0);
            end else if (in_flight) begin
                check("busy_inflight", busy, 1);
                check("in_ready_inflight", in_ready, 0);
            end
        end
    end

    // Called at posedge+1 with the DUT idle.
    task automatic run_claim(input logic [31:0] cn, input logic [31:0] ca,
                             input logic [31:0] cr, input logic [31:0] cp,
                             input logic [31:0] cq, input int hold, input bit poke);
        int cnt;
        model(cn, ca, cr, cp, cq, exp_accept, exp_status, exp_mu, exp_lat);
        check("in_ready_idle", in_ready, 1);
        N = cn; a = ca; r = cr; p = cp; q = cq;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_flight = 1'b1;
        cnt = 0;
        while (!out_valid && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!out_valid) begin
            check("verdict_timeout", cnt, exp_lat);
            rst_n = 1'b0;
            in_flight = 1'b0;
            #1 rst_n = 1'b1;
            @(posedge clk); #1;
            return;
        end
        check("latency", cnt, exp_lat);
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                N = $urandom; a = $urandom; r = $urandom_range(1, 20);
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            check("ov_held", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_flight = 1'b0;
        check("ov_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    int unsigned primes [16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};

    initial begin
        bit m_acc;
        logic [4:0] m_st;
        int m_mu, m_lat, mode, sub, ord;
        logic [31:0] rn, ra, rr, rp, rq;

        // Hand-computed anchors for the model itself.
        model(15, 7, 4, 3, 5, m_acc, m_st, m_mu, m_lat);
        check("pin_15_7_4_acc", m_acc, 1);
        check("pin_15_7_4_st", m_st, EN ? 5'b01111 : 5'b01011);
        check("pin_15_7_4_mu", m_mu, EN ? 19 : 16);
        check("pin_15_7_4_lat", m_lat, EN ? 13 : 10);
        model(15, 7, 8, 3, 5, m_acc, m_st, m_mu, m_lat);
        check("pin_15_7_8_acc", m_acc, EN ? 0 : 1);
        check("pin_15_7_8_st", m_st, 5'b00011);
        check("pin_15_7_8_mu", m_mu, EN ? 23 : 19);
        model(1, 9, 4, 3, 5, m_acc, m_st, m_mu, m_lat);
        check("pin_n1_st", m_st, 5'b10000);
        check("pin_n1_mu_lat", m_mu * 100 + m_lat, 402);
        model(21, 2, 6, 3, 7, m_acc, m_st, m_mu, m_lat);
        check("pin_21_2_6_st", m_st, EN ? 5'b01111 : 5'b01011);
        check("pin_21_2_6_mu", m_mu, EN ? 21 : 16);

        // Reset state.
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_accept", accept, 0);
        check("rst_status", status, 0);
        check("rst_mu", mu_cost, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed claims.
        run_claim(15, 7, 4, 3, 5, 0, 0);
        run_claim(15, 7, 8, 3, 5, 1, 0);
        run_claim(15, 7, 4, 3, 4, 2, 0);
        run_claim(1, 123, 77, 5, 9, 0, 0);
        run_claim(0, 5, 4, 3, 5, 0, 0);
        run_claim(15, 7, 0, 3, 5, 0, 0);
        run_claim(15, 7, 256, 3, 5, 0, 0);
        run_claim(15, 7, 257, 3, 5, 0, 0);
        run_claim(15, 1, 1, 3, 5, 0, 0);
        run_claim(15, 0, 2, 3, 5, 0, 0);
        run_claim(15, 7, 4, 3, 5, 10, 1);

        // Reset during POW_R aborts the claim with no verdict.
        N = 15; a = 7; r = 200; p = 3; q = 5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_flight = 1'b1;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        in_flight = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_status", status, 0);
        check("abort_mu", mu_cost, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_verdict", out_valid, 0);
        end
        run_claim(21, 2, 6, 3, 7, 0, 0);

        // Randomized claims.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 5);
            case (mode)
                0, 1, 2: begin
                    rp = primes[$urandom_range(0, 15)];
                    rq = primes[$urandom_range(0, 15)];
                    rn = rp * rq;
                    ra = $urandom_range(2, rn - 1);
                    ord = order_of(ra % rn, rn);
                    if (ord == 0)
                        rr = $urandom_range(1, 40);
                    else if (mode == 1 && ord * 2 <= 256)
                        rr = ord * 2;
                    else
                        rr = ord;
                    if (mode == 2) rq = rq + 2;
                end
                3: begin
                    rn = $urandom; ra = $urandom; rp = $urandom; rq = $urandom;
                    rr = $urandom_range(1, 256);
                end
                4: begin
                    sub = $urandom_range(0, 2);
                    rn = (sub == 0) ? $urandom_range(0, 1) : $urandom_range(2, 1000);
                    ra = $urandom; rp = $urandom_range(0, 50); rq = $urandom_range(0, 50);
                    rr = (sub == 1) ? 0 : (sub == 2) ? $urandom_range(257, 5000) : $urandom_range(1, 30);
                end
                default: begin
                    rn = $urandom_range(2, 300); ra = $urandom;
                    rr = $urandom_range(1, 60);
                    rp = $urandom_range(0, 20); rq = $urandom_range(0, 20);
                end
            endcase
            run_claim(rn, ra, rr, rp, rq, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shor_claim_verifier.md
Name: shor_claim_verifier

Overview:
- Checker at the opposite end of the Shor period-finding flow: accepts a claimed (N, a, r, p, q) certificate and independently verifies it.
- Checks performed:
  - p*q == N.
  - a^r ≡ 1 (mod N).
  - r is minimal.
  - gcd(a^(r/2)-1, N) reproduces p or q.
- Sits beside the period-finding engine in the partition_discovery cluster and charges μ-cost for verification work.
- Provides the falsifiability path: any bad period or factor claim is rejected.

Parameters:
- WIDTH, 32, bit width of N, a, r, p, q.
- MAX_PERIOD, 256, largest legal claimed period.
- MU_WIDTH, 16, width of μ-cost counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  claim present.
- in_ready  out  1  high in IDLE only.
- N  in  WIDTH  modulus.
- a  in  WIDTH  base.
- r  in  WIDTH  claimed period.
- p  in  WIDTH  claimed factor 1.
- q  in  WIDTH  claimed factor 2.
- out_valid  out  1  verdict present; held until out_ready.
- out_ready  in  1  consumer accepts verdict.
- accept  out  1  overall verdict.
- status  out  5  [0] product_ok, [1] period_ok, [2] minimal_ok, [3] derived_ok, [4] input_error.
- mu_cost  out  MU_WIDTH  μ-bits charged for this claim.
- busy  out  1  high from capture until out_valid.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0 except in_ready=1; state=IDLE. Reset mid-operation aborts immediately; no verdict is emitted.
- Capture (in_valid & in_ready in IDLE):
  - Latch inputs; a_r = a mod N (if N==0, a_r=0).
  - Clear mu_cost, status, accept; busy=1; go to PRECHECK.
- PRECHECK, 1 cycle, mu +4:
  - input_error = (N<2) | (r==0) | (r>MAX_PERIOD). If set, go to RESULT with all other status bits 0.
  - Otherwise product_ok = (p>1 & q>1 & full 2*WIDTH product p*q == N); go to POW_R.
- POW_R: right-to-left square-and-multiply for a_r^r mod N.
  - acc=1, base=a_r, e=r. Per cycle: if e[0], acc=(acc*base)%N; base=(base*base)%N; e>>=1; mu +2.
  - Products are 2*WIDTH bits. Leave the state when e becomes 0 (cycles = bit length of r).
  - period_ok = (acc==1).
  - If r is even, go to POW_HALF with e=r>>1. Otherwise derived_ok=0 and go to MIN_SCAN.
- POW_HALF: same engine computing h = a_r^(r/2) mod N, then go to GCD.
- GCD: Euclid, one step per cycle.
  - Init x = (h==0) ? N-1 : h-1; y = N.
  - While y!=0: (x,y)=(y, x%y), mu +1. The terminating cycle (y==0) charges nothing.
  - g = x; derived_ok = (g==p | g==q). Then go to MIN_SCAN.
- MIN_SCAN: see Optional Feature.
- RESULT: one cycle. Drive out_valid=1, busy=0.
  - accept = product_ok & period_ok & minimal_ok & !input_error (minimal_ok term per the Optional Feature).
  - derived_ok is informational only.
- Output handshake:
  - out_valid, accept, status, mu_cost are held stable until out_valid & out_ready.
  - After the handshake: out_valid=0, in_ready=1 next cycle.
  - in_ready stays low while out_valid is pending.
- mu_cost saturates at 2^MU_WIDTH-1; it never wraps.
- a_r==0 with N≥2: acc stays 0, so period_ok=0. No special casing.

Optional Feature:
- Macro: SHOR_MINIMALITY_CHECK_EN.
- Defined: MIN_SCAN runs k=1..r-1.
  - res=(res*a_r)%N each cycle, starting from res=1; mu +1 per step.
  - minimal_ok=0 and exit immediately if res==1 at any k<r; otherwise minimal_ok=1.
  - r==1: zero steps, minimal_ok=1.
- Undefined:
  - MIN_SCAN is bypassed (0 cycles, no μ charge) and status[2]=0.
  - accept = product_ok & period_ok & !input_error.

Test Plan:
- N=15, a=7, r=4, p=3, q=5, EN defined -> accept=1, status=5'b01111, mu_cost=19 (4+6+4+2+3).
- N=15, a=7, r=8, p=3, q=5:
  - EN defined -> period_ok=1, minimal_ok=0 (exit at k=4), derived_ok=0 (gcd(0,15)=15), accept=0.
  - EN undefined -> accept=1, status=5'b00011.
- N=15, a=7, r=4, p=3, q=4 -> product_ok=0, status=5'b01110, accept=0.
- N=1, any other inputs -> status=5'b10000, accept=0, mu_cost=4, out_valid 2 cycles after capture.
- Valid claim with out_ready held low 10 cycles -> out_valid, accept, status, mu_cost stable throughout; in_ready=0; new in_valid ignored.
- Deassert rst_n during POW_R -> all outputs reset at once; no out_valid.
- Next capture (N=21, a=2, r=6, p=3, q=7) -> accept=1, derived_ok=1 (gcd(7,21)=7).
